// File: rtl/t3d_abs_unwrap.sv
// t3d_abs_unwrap: unwraps 17-bit single-turn encoder samples into a signed
// 32-bit multi-turn position. Also produces windowed velocity, counts rejected
// samples and raises a fault on frame timeout or repeated implausible jumps.
module t3d_abs_unwrap #(
   parameter int ClkFrequency  = 32400000,
   parameter int Bits          = 17,
   parameter int MaxStep       = 8192,
   parameter int TimeoutCycles = ClkFrequency / 500,
   parameter int VelWindow     = ClkFrequency / 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] raw_pos,
   input  logic        raw_valid,
   input  logic        fault_clear,
   output logic [31:0] position,
   output logic [31:0] velocity,
   output logic        valid,
   output logic        fault,
   output logic [15:0] err_count
);

   localparam int TW = $clog2(TimeoutCycles + 1);
   localparam int VW = $clog2(VelWindow + 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_TRACK,
      ST_FAULT
   } state_t;

   state_t            state_q,    state_d;
   logic [31:0]       position_q, position_d;
   logic [31:0]       velocity_q, velocity_d;
   logic [31:0]       snap_q,     snap_d;
   logic              valid_q,    valid_d;
   logic              fault_q,    fault_d;
   logic [15:0]       err_count_q, err_count_d;
   logic              seeded_q,   seeded_d;
   logic [Bits-1:0]   last_q,     last_d;
   logic [2:0]        rejcnt_q,   rejcnt_d;
   logic [TW-1:0]     timeout_q,  timeout_d;
   logic [VW-1:0]     win_q,      win_d;

   logic [Bits-1:0]   raw_s;
   logic [Bits-1:0]   diff;
   logic [31:0]       diff_ext;
   logic              step_ok;
   logic              win_end;
   logic              go_fault;

   // Only the single-turn field of raw_pos carries information.
   logic unused_raw_hi;
   assign unused_raw_hi = &{1'b0, raw_pos[31:Bits]};

   // Wrapped delta between the new sample and the last accepted one, read as signed.
   always_comb begin
      raw_s    = raw_pos[Bits-1:0];
      diff     = raw_s - last_q;
      diff_ext = {{(32 - Bits){diff[Bits-1]}}, diff};
      step_ok  = ($signed(diff_ext) <= MaxStep) && ($signed(diff_ext) >= -MaxStep);
      win_end  = (win_q == VW'(VelWindow - 1));
   end

   // Next-state and output logic for the INIT / TRACK / FAULT controller.
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case below can leave one unassigned and infer a latch.
      state_d     = state_q;
      position_d  = position_q;
      velocity_d  = velocity_q;
      snap_d      = snap_q;
      valid_d     = valid_q;
      fault_d     = fault_q;
      err_count_d = err_count_q;
      seeded_d    = seeded_q;
      last_d      = last_q;
      rejcnt_d    = rejcnt_q;
      timeout_d   = timeout_q;
      win_d       = win_q;
      go_fault    = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (raw_valid) begin
               // After a fault the position is kept; only the reference sample is refreshed.
               if (!seeded_q) begin
                  position_d = {{(32 - Bits){1'b0}}, raw_s};
                  seeded_d   = 1'b1;
               end
               last_d    = raw_s;
               snap_d    = position_d;
               win_d     = '0;
               timeout_d = TW'(TimeoutCycles);
               rejcnt_d  = '0;
               valid_d   = 1'b1;
               state_d   = ST_TRACK;
            end
         end

         ST_TRACK: begin
            // Velocity window uses the registered position; a sample landing on
            // the window edge is credited to the following window.
            if (win_end) begin
               velocity_d = position_q - snap_q;
               snap_d     = position_q;
               win_d      = '0;
            end else begin
               win_d = win_q + VW'(1);
            end

            if (raw_valid) begin
               if (step_ok) begin
                  position_d = position_q + diff_ext;
                  last_d     = raw_s;
                  rejcnt_d   = '0;
                  timeout_d  = TW'(TimeoutCycles);
               end else begin
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
                  rejcnt_d = rejcnt_q + 3'd1;
                  if (rejcnt_q == 3'd3) begin
                     go_fault = 1'b1;
                  end
               end
            end else if (timeout_q <= TW'(1)) begin
               go_fault = 1'b1;
            end else begin
               timeout_d = timeout_q - TW'(1);
            end

            if (go_fault) begin
               state_d    = ST_FAULT;
               valid_d    = 1'b0;
               fault_d    = 1'b1;
               velocity_d = '0;
            end
         end

         ST_FAULT: begin
            // Samples are ignored here, including one coinciding with fault_clear.
            velocity_d = '0;
            if (fault_clear) begin
               fault_d = 1'b0;
               state_d = ST_INIT;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State register with synchronous reset that overrides all other inputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_INIT;
         position_q  <= '0;
         velocity_q  <= '0;
         snap_q      <= '0;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
         err_count_q <= '0;
         seeded_q    <= 1'b0;
         last_q      <= '0;
         rejcnt_q    <= '0;
         timeout_q   <= TW'(TimeoutCycles);
         win_q       <= '0;
      end else begin
         state_q     <= state_d;
         position_q  <= position_d;
         velocity_q  <= velocity_d;
         snap_q      <= snap_d;
         valid_q     <= valid_d;
         fault_q     <= fault_d;
         err_count_q <= err_count_d;
         seeded_q    <= seeded_d;
         last_q      <= last_d;
         rejcnt_q    <= rejcnt_d;
         timeout_q   <= timeout_d;
         win_q       <= win_d;
      end
   end

   assign position  = position_q;
   assign velocity  = velocity_q;
   assign valid     = valid_q;
   assign fault     = fault_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_t3d_abs_unwrap.sv
// Bench for t3d_abs_unwrap: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the unwrapper.
module tb_t3d_abs_unwrap;

   localparam int TO   = 100;
   localparam int VWIN = 50;
   localparam int MAXS = 8192;
   localparam int MOD  = 131072;
   localparam int HALF = 65536;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] raw_pos;
   logic        raw_valid;
   logic        fault_clear;
   logic [31:0] position;
   logic [31:0] velocity;
   logic        valid;
   logic        fault;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode 0 = waiting for a seed, 1 = tracking, 2 = faulted.
   int          m_mode;
   logic [31:0] m_pos, m_vel, m_snap;
   int          m_last, m_rej, m_idle, m_tcyc, m_err;
   bit          m_seeded;

   t3d_abs_unwrap #(
      .ClkFrequency (32400000),
      .Bits         (17),
      .MaxStep      (MAXS),
      .TimeoutCycles(TO),
      .VelWindow    (VWIN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_pos    (raw_pos),
      .raw_valid  (raw_valid),
      .fault_clear(fault_clear),
      .position   (position),
      .velocity   (velocity),
      .valid      (valid),
      .fault      (fault),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One clock of the specified behaviour, applied to the model state.
   task automatic model_step(input bit r, input bit rv, input logic [31:0] raw, input bit fc);
      int          rr, d;
      logic [31:0] old;
      bit          wend, flt;
      if (r) begin
         m_mode = 0; m_pos = 0; m_vel = 0; m_snap = 0; m_err = 0;
         m_seeded = 0; m_last = 0; m_rej = 0; m_idle = 0; m_tcyc = 0;
         return;
      end
      rr = int'(raw[16:0]);
      case (m_mode)
         0: if (rv) begin
            if (!m_seeded) begin
               m_pos    = 32'(rr);
               m_seeded = 1;
            end
            m_last = rr; m_mode = 1; m_idle = 0; m_rej = 0; m_tcyc = 0; m_snap = m_pos;
         end
         1: begin
            old  = m_pos;
            wend = (m_tcyc % VWIN) == VWIN - 1;
            m_tcyc++;
            flt  = 0;
            if (rv) begin
               d = (rr - m_last) & (MOD - 1);
               if (d >= HALF) d -= MOD;
               if (d <= MAXS && d >= -MAXS) begin
                  m_pos  = m_pos + 32'(d);
                  m_last = rr; m_rej = 0; m_idle = 0;
               end else begin
                  if (m_err < 65535) m_err++;
                  m_rej++;
                  if (m_rej >= 4) flt = 1;
               end
            end else begin
               m_idle++;
               if (m_idle >= TO) flt = 1;
            end
            if (wend) begin
               m_vel  = old - m_snap;
               m_snap = old;
            end
            if (flt) begin
               m_mode = 2;
               m_vel  = 0;
            end
         end
         default: begin
            m_vel = 0;
            if (fc) m_mode = 0;
         end
      endcase
   endtask

   // Apply inputs for one clock, advance the model, then compare all outputs.
   task automatic cycle(input bit r, input bit rv, input logic [31:0] raw, input bit fc);
      rst = r; raw_valid = rv; raw_pos = raw; fault_clear = fc;
      @(posedge clk);
      #1;
      model_step(r, rv, raw, fc);
      rst = 1'b0; raw_valid = 1'b0; fault_clear = 1'b0;
      check("position",  position,          m_pos);
      check("velocity",  velocity,          m_vel);
      check("valid",     {31'd0, valid},    {31'd0, m_mode == 1});
      check("fault",     {31'd0, fault},    {31'd0, m_mode == 2});
      check("err_count", {16'd0, err_count}, 32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 0);
   endtask

   initial begin
      logic [31:0] raw;
      logic [31:0] pre;
      rst = 1'b1; raw_valid = 1'b0; raw_pos = '0; fault_clear = 1'b0;

      // Reset state and first seed.
      cycle(1, 0, 32'd0, 0);
      check("rst_position", position, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_err", {16'd0, err_count}, 32'd0);
      cycle(0, 1, 32'd100, 0);
      check("seed_position", position, 32'd100);
      check("seed_valid", {31'd0, valid}, 32'd1);
      check("seed_velocity", velocity, 32'd0);

      // Wrap in both directions.
      cycle(0, 1, 32'd131000, 0);
      check("wrap_back", position, 32'(-72));
      cycle(0, 1, 32'd40, 0);
      check("wrap_fwd", position, 32'd40);
      cycle(0, 1, 32'd131000, 0);
      check("wrap_return", position, 32'(-72));

      // Implausible jumps: rejection, then fault after four in a row.
      cycle(0, 1, 32'd1000, 0);
      cycle(0, 1, 32'd30000, 0);
      check("reject_pos", position, 32'd1000);
      check("reject_err", {16'd0, err_count}, 32'd1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 32'd30000, 0);
      check("rej_fault", {31'd0, fault}, 32'd1);
      check("rej_valid", {31'd0, valid}, 32'd0);
      check("rej_err4", {16'd0, err_count}, 32'd4);

      // Recover, then timeout exactly at TO idle cycles.
      cycle(0, 0, 32'd0, 1);
      cycle(0, 1, 32'd500, 0);
      check("reinit_pos", position, 32'd1000);
      check("reinit_valid", {31'd0, valid}, 32'd1);
      idle(TO - 1);
      check("pre_timeout", {31'd0, fault}, 32'd0);
      idle(1);
      check("timeout_fault", {31'd0, fault}, 32'd1);
      pre = position;
      cycle(0, 0, 32'd0, 1);
      cycle(0, 1, 32'd500, 0);
      check("post_to_pos", position, pre);

      // Constant-rate steps up then down.
      raw = 32'd500;
      for (int s = 0; s < 20; s++) begin
         idle(9);
         raw = raw + 32'd10;
         cycle(0, 1, raw, 0);
      end
      check("vel_pos", velocity, 32'd50);
      for (int s = 0; s < 20; s++) begin
         idle(9);
         raw = raw - 32'd10;
         cycle(0, 1, raw, 0);
      end
      check("vel_neg", velocity, 32'(-50));

      // fault_clear with a coincident sample drops the sample; next one reseeds last.
      idle(TO);
      check("fault_again", {31'd0, fault}, 32'd1);
      pre = position;
      cycle(0, 1, 32'd60000, 1);
      check("drop_valid", {31'd0, valid}, 32'd0);
      check("drop_fault", {31'd0, fault}, 32'd0);
      cycle(0, 1, 32'd70000, 0);
      check("reseed_pos", position, pre);
      cycle(0, 1, 32'd70100, 0);
      check("reseed_step", position, pre + 32'd100);

      // Reset in the middle of tracking.
      cycle(1, 1, 32'd70200, 1);
      check("midrst_pos", position, 32'd0);
      check("midrst_valid", {31'd0, valid}, 32'd0);
      check("midrst_err", {16'd0, err_count}, 32'd0);

      // Random traffic: dense samples first, then sparse ones that hit timeouts.
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 1500; i++) begin
            bit r, rv, fc;
            r  = ($urandom_range(0, 999) == 0);
            rv = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            fc = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) raw = $urandom;
            else raw = 32'(m_last + int'($urandom_range(0, 400)) - 200) | ($urandom & 32'hFFFE_0000);
            cycle(r, rv, raw, fc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
